// File: rtl/rfx_ad7641_pkg.sv
// Shared definitions for the AD7641 serial receive front end.
//   state_t            - receive FSM states
//   AD7641_DATA_WIDTH  - native ADC result width
//   CNV_BLANK          - cycles at the start of WAIT_BUSY where BUSY is ignored
//                        (two synchronizer stages plus the ADC's BUSY assert delay)
package rfx_ad7641_pkg;

  localparam int AD7641_DATA_WIDTH = 18;
  localparam int CNV_BLANK         = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CONV      = 3'd1,
    WAIT_BUSY = 3'd2,
    SHIFT     = 3'd3,
    OUT       = 3'd4
  } state_t;

endpackage

// File: rtl/rfx_ad7641_sync.sv
// Generic two-flop synchronizer for asynchronous level inputs.
//   clk_i  - destination clock
//   rst_i  - asynchronous active-high reset, output clears to 0
//   d_i    - asynchronous input
//   q_o    - synchronized output, two clk_i cycles behind d_i
module rfx_ad7641_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rfx_ad7641_serial_rx.sv
// AD7641 conversion pacer and serial receiver.
// Paces conversions from a free-running period counter, pulses CNVST, waits for
// BUSY to fall, clocks DATA_WIDTH bits out of SDOUT (MSB first) and presents the
// result on a valid/ready stream.
//   ACLK, ARESET  - clock, asynchronous active-high reset
//   enable        - run conversions while high
//   cnvst_o       - conversion start to the ADC
//   busy_i        - ADC BUSY (asynchronous, synchronized internally)
//   sclk_o        - serial clock to the ADC
//   sdout_i       - serial data from the ADC
//   m_data/m_valid/m_ready - sample stream
//   overrun       - 1-cycle pulse when a new sample is dropped
//   timeout       - 1-cycle pulse when BUSY never fell
//   sample_count  - number of accepted samples, wraps at 2^32
//   dbg_state_o   - current FSM state
//
// Stream handshake: a sample transfers on every cycle where m_valid && m_ready.
// m_valid never drops and m_data never changes while m_valid && !m_ready; a new
// sample is loaded only when the output register is empty or being accepted in
// the same cycle, otherwise it is dropped and overrun pulses.
module rfx_ad7641_serial_rx
  import rfx_ad7641_pkg::*;
#(
  parameter int DATA_WIDTH    = AD7641_DATA_WIDTH,
  parameter int CLK_DIV       = 2,
  parameter int CNV_PULSE     = 4,
  parameter int SAMPLE_PERIOD = 50,
  parameter int BUSY_TIMEOUT  = 64
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  enable,
  output logic                  cnvst_o,
  input  logic                  busy_i,
  output logic                  sclk_o,
  input  logic                  sdout_i,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  overrun,
  output logic                  timeout,
  output logic [31:0]           sample_count,
  output state_t                dbg_state_o
);

  localparam int PER_W = $clog2(SAMPLE_PERIOD);
  localparam int CNT_W = $clog2(CNV_PULSE + CNV_BLANK + BUSY_TIMEOUT + 1);
  localparam int PH_W  = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  state_t                state_q, state_d;
  logic [PER_W-1:0]      per_q, per_d;
  logic                  pending_q, pending_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PH_W-1:0]       ph_q, ph_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  sclk_q, sclk_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [31:0]           count_q, count_d;
  logic                  busy_s;
  logic                  tick;
  logic                  go_conv;

  rfx_ad7641_sync #(.WIDTH(1)) u_busy_sync (
    .clk_i (ACLK),
    .rst_i (ARESET),
    .d_i   (busy_i),
    .q_o   (busy_s)
  );

  // Period counter and pending-trigger flag. A tick arriving while a trigger is
  // already pending is absorbed; IDLE may consume a tick in the cycle it occurs.
  always_comb begin
    tick      = enable && (per_q == PER_W'(SAMPLE_PERIOD - 1));
    per_d     = per_q + 1'b1;
    if (!enable || tick) per_d = '0;
    pending_d = (pending_q || tick) && !go_conv;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    go_conv = 1'b0;
    overrun = 1'b0;
    timeout = 1'b0;

    if (valid_q && m_ready) begin
      valid_d = 1'b0;
      count_d = count_q + 32'd1;
    end

    case (state_q)
      IDLE: begin
        if (enable && (pending_q || tick)) begin
          go_conv = 1'b1;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        if (cnt_q == CNT_W'(CNV_PULSE - 1)) begin
          cnt_d   = '0;
          state_d = WAIT_BUSY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_BUSY: begin
        // cnt_q counts every cycle spent here; the first CNV_BLANK are blind.
        if (cnt_q < CNT_W'(CNV_BLANK)) begin
          cnt_d = cnt_q + 1'b1;
        end else if (!busy_s) begin
          sclk_d  = 1'b1;
          ph_d    = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end else if (cnt_q == CNT_W'(CNV_BLANK + BUSY_TIMEOUT)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (ph_q == PH_W'(CLK_DIV - 1)) begin
          ph_d = '0;
          if (sclk_q) begin
            // Falling SCLK edge: capture the bit the ADC has been presenting.
            sclk_d  = 1'b0;
            shreg_d = {shreg_q[DATA_WIDTH-2:0], sdout_i};
          end else if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
            state_d = OUT;
          end else begin
            bit_d  = bit_q + 1'b1;
            sclk_d = 1'b1;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      OUT: begin
        if (!valid_q || m_ready) begin
          data_d  = shreg_q;
          valid_d = 1'b1;
        end else begin
          overrun = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      per_q     <= '0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      ph_q      <= '0;
      bit_q     <= '0;
      sclk_q    <= 1'b0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      per_q     <= per_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      ph_q      <= ph_d;
      bit_q     <= bit_d;
      sclk_q    <= sclk_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
    end
  end

  assign cnvst_o      = (state_q == CONV);
  assign sclk_o       = sclk_q;
  assign m_data       = data_q;
  assign m_valid      = valid_q;
  assign sample_count = count_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_rfx_ad7641_serial_rx.sv
module tb_rfx_ad7641_serial_rx;
  import rfx_ad7641_pkg::*;

  localparam int DW       = 18;
  localparam int BUSY_LOW = 20;
  // cnvst rise -> m_valid: BUSY low after 20, +2 sync, +1 decide, +72 shift, +1 OUT
  localparam int EXP_LAT  = 96;
  // WAIT_BUSY entry -> timeout pulse: 3 blank cycles + 64
  localparam int EXP_TMO  = 67;
  // cnvst rise to next cnvst rise when conversions run back to back
  localparam int EXP_INT  = 97;

  // ---------------- clock / reset ----------------
  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          enable;
  logic          cnvst_o;
  logic          busy_i = 1'b0;
  logic          sclk_o;
  logic          sdout_i = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          overrun;
  logic          timeout;
  logic [31:0]   sample_count;
  state_t        dbg_state;

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  rfx_ad7641_serial_rx #(
    .DATA_WIDTH    (DW),
    .CLK_DIV       (2),
    .CNV_PULSE     (4),
    .SAMPLE_PERIOD (20),
    .BUSY_TIMEOUT  (64)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .enable       (enable),
    .cnvst_o      (cnvst_o),
    .busy_i       (busy_i),
    .sclk_o       (sclk_o),
    .sdout_i      (sdout_i),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .overrun      (overrun),
    .timeout      (timeout),
    .sample_count (sample_count),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- ADC model + scoreboard ----------------
  logic [DW-1:0] adc_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cur_word = '0;
  bit  busy_forever = 1'b0;
  bit  prev_cnv = 1'b0, prev_sclk = 1'b0, have_prev = 1'b0;
  int  bit_idx = DW, bcnt = 0;
  int  cnv_rises = 0, sclk_rises = 0, ovr_cnt = 0, tmo_cnt = 0, vld_cnt = 0;
  int  cnv_rise_cyc = 0, cnv_fall_cyc = 0, min_int = 1 << 30, max_int = 0;

  always @(negedge ACLK) begin
    #1;
    if (ARESET) begin
      busy_i = 1'b0; sdout_i = 1'b0; bit_idx = DW; bcnt = 0;
      prev_cnv = 1'b0; prev_sclk = 1'b0; have_prev = 1'b0;
      cnv_rises = 0; sclk_rises = 0; ovr_cnt = 0; tmo_cnt = 0; vld_cnt = 0;
      min_int = 1 << 30; max_int = 0;
    end else begin
      if (cnvst_o && !prev_cnv) begin
        if (adc_q.size() > 0) cur_word = adc_q.pop_front();
        else cur_word = '0;
        busy_i = 1'b1; bcnt = 0; bit_idx = 0; sclk_rises = 0; cnv_rises++;
        if (have_prev) begin
          if (cyc - cnv_rise_cyc < min_int) min_int = cyc - cnv_rise_cyc;
          if (cyc - cnv_rise_cyc > max_int) max_int = cyc - cnv_rise_cyc;
        end
        have_prev = 1'b1;
        cnv_rise_cyc = cyc;
      end else if (busy_i) begin
        bcnt++;
        if (bcnt >= BUSY_LOW && !busy_forever) busy_i = 1'b0;
      end
      if (!cnvst_o && prev_cnv) cnv_fall_cyc = cyc;
      if (sclk_o && !prev_sclk) sclk_rises++;
      if (!sclk_o && prev_sclk) bit_idx++;
      sdout_i = (bit_idx < DW) ? cur_word[DW-1-bit_idx] : 1'b0;
      prev_cnv  = cnvst_o;
      prev_sclk = sclk_o;
      if (overrun) ovr_cnt++;
      if (timeout) tmo_cnt++;
      if (m_valid) vld_cnt++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check_eq("sb_unexpected", 32'(exp_q.size()), 32'd1);
        else check_eq("sb_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic bit sig_now(input int which);
    case (which)
      0: return m_valid;
      1: return overrun;
      2: return timeout;
      3: return dbg_state == SHIFT;
      default: return sclk_o;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int max_cyc, input string tag);
    int n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!sig_now(which) && n < max_cyc);
    check_eq(tag, 32'(sig_now(which)), 32'd1);
  endtask

  task automatic do_reset();
    enable = 1'b0;
    ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  logic [DW-1:0] t6_words [10] = '{18'h00001, 18'h3FFFE, 18'h15555, 18'h2AAAA, 18'h0F0F0,
                                   18'h30303, 18'h1C71C, 18'h23456, 18'h3C3C3, 18'h00F00};
  logic [3:0] acc;
  int snap;

  // ---------------- stimulus ----------------
  initial begin
    ARESET = 1'b1; enable = 1'b1; m_ready = 1'b0;

    // 1: outputs held at zero during reset
    acc = '0;
    repeat (10) begin
      @(negedge ACLK);
      acc = acc | {cnvst_o, sclk_o, m_valid, |sample_count};
    end
    check_eq("t1_rst_outputs", 32'(acc), 32'd0);
    check_eq("t1_state_idle", 32'(dbg_state), 32'(IDLE));

    // 2: single conversion, latency and bit count
    adc_q.push_back(18'h2A5C3); exp_q.push_back(18'h2A5C3);
    m_ready = 1'b1;
    ARESET  = 1'b0;
    wait_sig(0, 400, "t2_valid_seen");
    enable = 1'b0;
    check_eq("t2_data", 32'(m_data), 32'h2A5C3);
    check_eq("t2_latency", 32'(cyc - cnv_rise_cyc), 32'(EXP_LAT));
    check_eq("t2_sclk_rises", 32'(sclk_rises), 32'd18);
    @(negedge ACLK);
    check_eq("t2_valid_one_cycle", 32'(m_valid), 32'd0);
    check_eq("t2_count", sample_count, 32'd1);
    check_eq("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // 3: backpressure holds data, second sample overruns
    do_reset();
    m_ready = 1'b0;
    adc_q.push_back(18'h3FFFF); adc_q.push_back(18'h00001);
    exp_q.push_back(18'h3FFFF);
    enable = 1'b1;
    wait_sig(0, 400, "t3_first_valid");
    check_eq("t3_first_data", 32'(m_data), 32'h3FFFF);
    wait_sig(1, 300, "t3_overrun_seen");
    enable = 1'b0;
    repeat (5) @(negedge ACLK);
    check_eq("t3_overrun_cnt", 32'(ovr_cnt), 32'd1);
    check_eq("t3_data_held", 32'(m_data), 32'h3FFFF);
    check_eq("t3_valid_held", 32'(m_valid), 32'd1);
    check_eq("t3_count_before", sample_count, 32'd0);
    m_ready = 1'b1;
    @(negedge ACLK);
    check_eq("t3_valid_cleared", 32'(m_valid), 32'd0);
    check_eq("t3_count_after", sample_count, 32'd1);
    check_eq("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // 4: BUSY stuck high -> timeout, then recovery
    do_reset();
    busy_forever = 1'b1;
    adc_q.push_back(18'h00000); adc_q.push_back(18'h0ABCD);
    exp_q.push_back(18'h0ABCD);
    m_ready = 1'b1;
    enable  = 1'b1;
    wait_sig(2, 300, "t4_timeout_seen");
    busy_forever = 1'b0;
    check_eq("t4_timeout_delay", 32'(cyc - cnv_fall_cyc), 32'(EXP_TMO));
    check_eq("t4_no_valid", 32'(m_valid), 32'd0);
    @(negedge ACLK);
    check_eq("t4_state_idle", 32'(dbg_state), 32'(IDLE));
    wait_sig(0, 300, "t4_next_valid");
    enable = 1'b0;
    check_eq("t4_data", 32'(m_data), 32'h0ABCD);
    check_eq("t4_timeout_cnt", 32'(tmo_cnt), 32'd1);
    @(negedge ACLK);
    check_eq("t4_count", sample_count, 32'd1);

    // 5: enable dropped mid-shift, then reset mid-shift
    do_reset();
    adc_q.push_back(18'h12345); exp_q.push_back(18'h12345);
    m_ready = 1'b1;
    enable  = 1'b1;
    wait_sig(3, 300, "t5_shift_seen");
    enable = 1'b0;
    wait_sig(0, 200, "t5_valid_seen");
    check_eq("t5_data", 32'(m_data), 32'h12345);
    snap = cnv_rises;
    repeat (100) @(negedge ACLK);
    check_eq("t5_no_more_cnvst", 32'(cnv_rises - snap), 32'd0);
    adc_q.push_back(18'h0F0F0);
    enable = 1'b1;
    wait_sig(3, 300, "t5_shift2_seen");
    wait_sig(4, 20, "t5_sclk_high");
    ARESET = 1'b1;
    #1;
    check_eq("t5_sclk_async_drop", 32'(sclk_o), 32'd0);
    check_eq("t5_state_async", 32'(dbg_state), 32'(IDLE));
    enable = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    repeat (150) @(negedge ACLK);
    check_eq("t5_no_valid_after_rst", 32'(vld_cnt), 32'd0);
    check_eq("t5_count_after_rst", sample_count, 32'd0);

    // 6: period shorter than a conversion, ten back-to-back samples
    do_reset();
    for (int i = 0; i < 10; i++) begin
      adc_q.push_back(t6_words[i]);
      exp_q.push_back(t6_words[i]);
    end
    m_ready = 1'b1;
    enable  = 1'b1;
    for (int i = 0; i < 10; i++) wait_sig(0, 300, "t6_valid_seen");
    enable = 1'b0;
    @(negedge ACLK);
    check_eq("t6_count", sample_count, 32'd10);
    check_eq("t6_overrun_cnt", 32'(ovr_cnt), 32'd0);
    check_eq("t6_cnvst_cnt", 32'(cnv_rises), 32'd10);
    check_eq("t6_min_interval", 32'(min_int), 32'(EXP_INT));
    check_eq("t6_max_interval", 32'(max_int), 32'(EXP_INT));
    check_eq("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
